// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state shared by the multi-cycle ALU.
// Opcodes ALU_AND..ALU_MUL; state_t {IDLE, MUL}.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_LSL = 4'b0011;
  localparam logic [3:0] ALU_LSR = 4'b0100;
  localparam logic [3:0] ALU_ASR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_PSB = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: operand/result valid-ready bundle for the ALU.
// master = producer/consumer side, slave = ALU side.
interface alu_multicycle_if #(
  parameter int WIDTH = 64
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic [3:0]       ALUCtrl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] BusW;
  logic             Zero;
  logic             Negative;
  logic             Carry;
  logic             Overflow;
  logic             Busy;

  modport master (
    output InValid, BusA, BusB, ALUCtrl, OutReady,
    input  InReady, OutValid, BusW,
    input  Zero, Negative, Carry, Overflow, Busy
  );

  modport slave (
    input  InValid, BusA, BusB, ALUCtrl, OutReady,
    output InReady, OutValid, BusW,
    output Zero, Negative, Carry, Overflow, Busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one B bit per cycle.
// start_i latches a_i/b_i; done_o/prod_o valid on the last iteration.
module alu_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);
  localparam int SHW = $clog2(WIDTH);

  logic             run_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d  = b_q[0] ? acc_q + a_q : acc_q;
  // Product is the accumulator after the final add; the top registers it.
  assign done_o = run_q && (cnt_q == SHW'(WIDTH - 1));
  assign prod_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
    end else if (run_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with registered result/NZCV flags.
// Ports: CLK, Reset_L, bus (slave: In*/Bus*/Out*/flags/Busy).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic          CLK,
  input logic          Reset_L,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] w_q;
  logic             z_q;
  logic             n_q;
  logic             c_q;
  logic             v_q;
  logic             ov_q;

  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res;
  logic             c_alu;
  logic             v_alu;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic             load;
  logic [WIDTH-1:0] w_d;
  logic             c_d;
  logic             v_d;

  assign op = bus.ALUCtrl;
  assign a  = bus.BusA;
  assign b  = bus.BusB;

  assign bus.InReady  = (state_q == IDLE) && (!ov_q || bus.OutReady);
  assign bus.OutValid = ov_q;
  assign bus.BusW     = w_q;
  assign bus.Zero     = z_q;
  assign bus.Negative = n_q;
  assign bus.Carry    = c_q;
  assign bus.Overflow = v_q;
  assign bus.Busy     = (state_q == MUL);

  assign accept = bus.InValid && bus.InReady;
  assign is_mul = (op == ALU_MUL);

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    sh    = b[SHW-1:0];
    res   = '0;
    c_alu = 1'b0;
    v_alu = 1'b0;
    unique case (1'b1)
      (op == ALU_AND): res = a & b;
      (op == ALU_OR):  res = a | b;
      (op == ALU_ADD): begin
        res   = sum[WIDTH-1:0];
        c_alu = sum[WIDTH];
        v_alu = (a[WIDTH-1] == b[WIDTH-1]) &&
                (res[WIDTH-1] != a[WIDTH-1]);
      end
      (op == ALU_LSL): res = a << sh;
      (op == ALU_LSR): res = a >> sh;
      (op == ALU_ASR): res = $unsigned($signed(a) >>> sh);
      (op == ALU_SUB): begin
        res   = dif[WIDTH-1:0];
        // Carry is NOT borrow: set when A >= B unsigned.
        c_alu = !dif[WIDTH];
        v_alu = (a[WIDTH-1] != b[WIDTH-1]) &&
                (res[WIDTH-1] != a[WIDTH-1]);
      end
      (op == ALU_PSB): res = b;
      default:         res = '0;
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (CLK),
    .rst_n  (Reset_L),
    .start_i(accept && is_mul),
    .a_i    (a),
    .b_i    (b),
    .done_o (mul_done),
    .prod_o (mul_p)
  );

  // Accept is impossible in MUL, so the two load sources never collide.
  assign load = mul_done || (accept && !is_mul);
  assign w_d  = mul_done ? mul_p : res;
  assign c_d  = mul_done ? 1'b0 : c_alu;
  assign v_d  = mul_done ? 1'b0 : v_alu;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      w_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (load) begin
        w_q  <= w_d;
        z_q  <= (w_d == '0);
        n_q  <= w_d[WIDTH-1];
        c_q  <= c_d;
        v_q  <= v_d;
        ov_q <= 1'b1;
      end else if (bus.OutReady) begin
        ov_q <= 1'b0;
      end
      case (state_q)
        IDLE:    if (accept && is_mul) state_q <= MUL;
        MUL:     if (mul_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: random + directed checks of alu_multicycle.
// Reference model computes results from plain integer arithmetic.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(64)) if64 ();
  alu_multicycle_if #(.WIDTH(8))  if8 ();

  alu_multicycle #(.WIDTH(64)) dut (
    .CLK(clk), .Reset_L(rst_n), .bus(if64)
  );
  alu_multicycle #(.WIDTH(8)) dut8 (
    .CLK(clk), .Reset_L(rst_n), .bus(if8)
  );

  // {result, Z, N, C, V}
  function automatic logic [67:0] model(input logic [3:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r, ones;
    logic c, v;
    logic [64:0] w;
    logic [127:0] p;
    logic signed [65:0] s;
    int unsigned sh;
    r = '0; c = 1'b0; v = 1'b0; ones = '1;
    sh = int'(b[5:0]);
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[63:0]; c = w[64];
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        v = (s != $signed({{2{r[63]}}, r}));
      end
      4'd3: r = a << sh;
      4'd4: r = a >> sh;
      4'd5: begin
        r = a >> sh;
        if (a[63]) r = r | ~(ones >> sh);
      end
      4'd6: begin
        r = a - b; c = (a >= b);
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        v = (s != $signed({{2{r[63]}}, r}));
      end
      4'd7: r = b;
      4'd8: begin
        p = {64'b0, a} * {64'b0, b};
        r = p[63:0];
      end
      default: r = '0;
    endcase
    return {r, (r == 64'd0), r[63], c, v};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    if64.InValid = 1'b0; if64.OutReady = 1'b1;
    if64.BusA = '0; if64.BusB = '0; if64.ALUCtrl = '0;
    if8.InValid = 1'b0; if8.OutReady = 1'b1;
    if8.BusA = '0; if8.BusB = '0; if8.ALUCtrl = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({if64.BusW, if64.Zero, if64.Negative, if64.Carry,
         if64.Overflow, if64.OutValid, if64.Busy} !== '0) begin
      bad++;
      $display("FAIL reset64 got W=%h ov=%b busy=%b want all 0",
               if64.BusW, if64.OutValid, if64.Busy);
    end
    total++;
    if ({if8.BusW, if8.Zero, if8.OutValid, if8.Busy} !== '0) begin
      bad++;
      $display("FAIL reset8 got W=%h ov=%b want 0", if8.BusW, if8.OutValid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (if64.InReady !== 1'b1 || if64.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got rdy=%b ov=%b want 1 0",
               if64.InReady, if64.OutValid);
    end
  endtask

  task automatic test_directed;
    logic [3:0]  ops [6];
    logic [63:0] as [6];
    logic [63:0] bs [6];
    logic [67:0] want [6];
    logic [67:0] obs;
    ops[0] = 4'd2; as[0] = '1; bs[0] = 64'd1;
    want[0] = {64'd0, 4'b1010};
    ops[1] = 4'd6; as[1] = 64'h7FFF_FFFF_FFFF_FFFF; bs[1] = '1;
    want[1] = {64'h8000_0000_0000_0000, 4'b0101};
    ops[2] = 4'd5; as[2] = 64'h8000_0000_0000_0000; bs[2] = 64'h43;
    want[2] = {64'hF000_0000_0000_0000, 4'b0100};
    ops[3] = 4'd4; as[3] = 64'h8000_0000_0000_0000; bs[3] = 64'h43;
    want[3] = {64'h1000_0000_0000_0000, 4'b0000};
    ops[4] = 4'b1011; as[4] = 64'h1234; bs[4] = 64'h55;
    want[4] = {64'd0, 4'b1000};
    ops[5] = 4'd6; as[5] = 64'd5; bs[5] = 64'd5;
    want[5] = {64'd0, 4'b1010};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if64.InValid = 1'b1; if64.ALUCtrl = ops[i];
      if64.BusA = as[i]; if64.BusB = bs[i];
      @(negedge clk);
      if64.InValid = 1'b0;
      obs = {if64.BusW, if64.Zero, if64.Negative,
             if64.Carry, if64.Overflow};
      total++;
      if (obs !== want[i] || if64.OutValid !== 1'b1) begin
        bad++;
        $display("FAIL directed%0d got %h ov=%b want %h", i, obs,
                 if64.OutValid, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [67:0] exp, obs;
    logic pend;
    logic [3:0] op;
    pend = 1'b0; exp = '0;
    for (int i = 0; i <= 150; i++) begin
      @(negedge clk);
      if (pend) begin
        obs = {if64.BusW, if64.Zero, if64.Negative,
               if64.Carry, if64.Overflow};
        total++;
        if (obs !== exp || if64.OutValid !== 1'b1) begin
          bad++;
          $display("FAIL b2b%0d got %h ov=%b want %h", i, obs,
                   if64.OutValid, exp);
        end
      end
      if (i < 150) begin
        total++;
        if (if64.InReady !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready%0d got %b want 1", i, if64.InReady);
        end
        op = 4'($urandom_range(0, 15));
        if (op == 4'd8) op = 4'd7;
        if64.InValid = 1'b1; if64.ALUCtrl = op;
        if64.BusA = pick(); if64.BusB = pick();
        exp = model(op, if64.BusA, if64.BusB);
        pend = 1'b1;
      end else begin
        if64.InValid = 1'b0;
      end
    end
  endtask

  task automatic do_mul(input logic [63:0] a, input logic [63:0] b);
    logic [67:0] exp, obs;
    int n;
    exp = model(4'd8, a, b);
    @(negedge clk);
    if64.InValid = 1'b1; if64.ALUCtrl = 4'd8;
    if64.BusA = a; if64.BusB = b; if64.OutReady = 1'b1;
    @(negedge clk);
    // Junk ADD held on the bus must be ignored while busy.
    if64.ALUCtrl = 4'd2; if64.BusA = {$urandom, $urandom};
    n = 0;
    while (if64.OutValid !== 1'b1 && n < 80) begin
      total++;
      if (if64.Busy !== 1'b1 || if64.InReady !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy cyc%0d got busy=%b rdy=%b want 1 0",
                 n, if64.Busy, if64.InReady);
      end
      @(negedge clk);
      n++;
    end
    if64.InValid = 1'b0;
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL mul_latency got %0d want 64", n);
    end
    obs = {if64.BusW, if64.Zero, if64.Negative,
           if64.Carry, if64.Overflow};
    total++;
    if (obs !== exp || if64.Busy !== 1'b0) begin
      bad++;
      $display("FAIL mul_result got %h busy=%b want %h", obs,
               if64.Busy, exp);
    end
  endtask

  task automatic test_mul;
    do_mul(64'h1234_5678, 64'h9ABC);
    do_mul({$urandom, $urandom}, {$urandom, $urandom});
    do_mul('1, '1);
  endtask

  task automatic test_mul8;
    logic [7:0] a, b, r;
    logic [15:0] p;
    int n;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 8'h0F : 8'($urandom);
      b = (k == 0) ? 8'h11 : 8'($urandom);
      p = {8'b0, a} * {8'b0, b};
      r = p[7:0];
      @(negedge clk);
      if8.InValid = 1'b1; if8.ALUCtrl = 4'd8;
      if8.BusA = a; if8.BusB = b;
      @(negedge clk);
      if8.InValid = 1'b0;
      n = 0;
      while (if8.OutValid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n != 8 || {if8.BusW, if8.Zero, if8.Negative}
                    !== {r, r == 8'd0, r[7]}) begin
        bad++;
        $display("FAIL mul8_%0d got W=%h lat=%0d want W=%h lat=8",
                 k, if8.BusW, n, r);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [67:0] exp, exp2, obs;
    logic [63:0] a, b;
    a = pick(); b = pick();
    exp = model(4'd2, a, b);
    @(negedge clk);
    if64.InValid = 1'b1; if64.ALUCtrl = 4'd2;
    if64.BusA = a; if64.BusB = b; if64.OutReady = 1'b0;
    @(negedge clk);
    if64.InValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {if64.BusW, if64.Zero, if64.Negative,
             if64.Carry, if64.Overflow};
      total++;
      if (obs !== exp || if64.OutValid !== 1'b1 ||
          if64.InReady !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got %h ov=%b rdy=%b want %h 1 0", i,
                 obs, if64.OutValid, if64.InReady, exp);
      end
      if64.BusA = {$urandom, $urandom};
      @(negedge clk);
    end
    a = pick(); b = pick();
    exp2 = model(4'd6, a, b);
    if64.OutReady = 1'b1; if64.InValid = 1'b1;
    if64.ALUCtrl = 4'd6; if64.BusA = a; if64.BusB = b;
    #1;
    total++;
    if (if64.InReady !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready got %b want 1", if64.InReady);
    end
    @(negedge clk);
    if64.InValid = 1'b0;
    obs = {if64.BusW, if64.Zero, if64.Negative,
           if64.Carry, if64.Overflow};
    total++;
    if (obs !== exp2 || if64.OutValid !== 1'b1) begin
      bad++;
      $display("FAIL bp_replace got %h ov=%b want %h 1", obs,
               if64.OutValid, exp2);
    end
    @(negedge clk);
    total++;
    if (if64.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got ov=%b want 0", if64.OutValid);
    end
  endtask

  task automatic test_reset_mid_mul;
    @(negedge clk);
    if64.InValid = 1'b1; if64.ALUCtrl = 4'd8;
    if64.BusA = {$urandom, $urandom}; if64.BusB = '1;
    @(negedge clk);
    if64.InValid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (if64.OutValid !== 1'b0 || if64.BusW !== '0 ||
        if64.Busy !== 1'b0 || if64.InReady !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got ov=%b W=%h busy=%b rdy=%b",
               if64.OutValid, if64.BusW, if64.Busy, if64.InReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_mul({$urandom, $urandom}, 64'h1234_5678_9ABC_DEF1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mul();
    test_mul8();
    test_backpressure();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
